// File: rtl/abro_sequencer_if.sv
// Bundles the ABRO sequencer control inputs and status outputs.
// The slave modport belongs to the sequencer and the master modport to its driver.
interface abro_sequencer_if #(
  parameter int TIMEOUT_W = 8,
  parameter int CNT_W     = 8
);
  logic                 R;
  logic                 A;
  logic                 B;
  logic                 timeout_en;
  logic [TIMEOUT_W-1:0] timeout_cfg;
  logic                 O;
  logic [2:0]           state;
  logic                 seen_a;
  logic                 seen_b;
  logic                 timed_out;
  logic [CNT_W-1:0]     o_count;

  modport master (
    output R, A, B, timeout_en, timeout_cfg,
    input  O, state, seen_a, seen_b, timed_out, o_count
  );

  modport slave (
    input  R, A, B, timeout_en, timeout_cfg,
    output O, state, seen_a, seen_b, timed_out, o_count
  );
endinterface

// File: rtl/abro_sequencer.sv
// ABRO sequencer: latches A and B in any order and emits one registered O pulse.
// It then halts until R re-arms it, and an optional timer bounds the partial-match states.
module abro_sequencer #(
  parameter int TIMEOUT_W = 8,
  parameter int CNT_W     = 8
) (
  input  logic            clk,
  input  logic            reset,
  abro_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_WAIT_AB = 3'd0,
    S_WAIT_A  = 3'd1,
    S_WAIT_B  = 3'd2,
    S_EMIT    = 3'd3,
    S_HALT    = 3'd4,
    S_TIMEOUT = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_o;
  logic                 r_seen_a;
  logic                 r_seen_b;
  logic                 r_timed_out;
  logic [TIMEOUT_W-1:0] r_timer;
  logic [CNT_W-1:0]     r_count;
  logic                 w_seen_a_next;
  logic                 w_seen_b_next;
  logic                 w_timed_out_next;
  logic [TIMEOUT_W-1:0] w_timer_next;
  logic                 w_timer_active;
  logic                 w_expire;

  // The timer expires on the edge at which its incremented value would reach the limit.
  assign w_timer_active = bus.timeout_en && (bus.timeout_cfg != {TIMEOUT_W{1'b0}});
  assign w_expire = w_timer_active &&
                    (({1'b0, r_timer} + {{TIMEOUT_W{1'b0}}, 1'b1}) >= {1'b0, bus.timeout_cfg});

  // Next-state, seen flags, sticky timeout and timer; R overrides every other input.
  always_comb begin
    w_next_state     = r_state;
    w_seen_a_next    = r_seen_a;
    w_seen_b_next    = r_seen_b;
    w_timed_out_next = r_timed_out;
    w_timer_next     = {TIMEOUT_W{1'b0}};
    if (bus.R) begin
      w_next_state     = S_WAIT_AB;
      w_seen_a_next    = 1'b0;
      w_seen_b_next    = 1'b0;
      w_timed_out_next = 1'b0;
    end else begin
      case (r_state)
        S_WAIT_AB: begin
          if (bus.A && bus.B) begin
            w_next_state  = S_EMIT;
            w_seen_a_next = 1'b1;
            w_seen_b_next = 1'b1;
          end else if (bus.A) begin
            w_next_state  = S_WAIT_B;
            w_seen_a_next = 1'b1;
          end else if (bus.B) begin
            w_next_state  = S_WAIT_A;
            w_seen_b_next = 1'b1;
          end else begin
            w_next_state = S_WAIT_AB;
          end
        end
        S_WAIT_A: begin
          if (bus.A) begin
            w_next_state  = S_EMIT;
            w_seen_a_next = 1'b1;
          end else if (w_expire) begin
            w_next_state     = S_TIMEOUT;
            w_timed_out_next = 1'b1;
          end else if (w_timer_active) begin
            w_timer_next = r_timer + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
          end else begin
            w_timer_next = r_timer;
          end
        end
        S_WAIT_B: begin
          if (bus.B) begin
            w_next_state  = S_EMIT;
            w_seen_b_next = 1'b1;
          end else if (w_expire) begin
            w_next_state     = S_TIMEOUT;
            w_timed_out_next = 1'b1;
          end else if (w_timer_active) begin
            w_timer_next = r_timer + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
          end else begin
            w_timer_next = r_timer;
          end
        end
        S_EMIT:    w_next_state = S_HALT;
        S_HALT:    w_next_state = S_HALT;
        S_TIMEOUT: w_next_state = S_TIMEOUT;
        default: begin
          w_next_state     = S_WAIT_AB;
          w_seen_a_next    = 1'b0;
          w_seen_b_next    = 1'b0;
          w_timed_out_next = 1'b0;
        end
      endcase
    end
  end

  // State and status registers; O is registered from the next state so it is high only in EMIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_WAIT_AB;
      r_o         <= 1'b0;
      r_seen_a    <= 1'b0;
      r_seen_b    <= 1'b0;
      r_timed_out <= 1'b0;
      r_timer     <= {TIMEOUT_W{1'b0}};
      r_count     <= {CNT_W{1'b0}};
    end else begin
      r_state     <= w_next_state;
      r_o         <= (w_next_state == S_EMIT);
      r_seen_a    <= w_seen_a_next;
      r_seen_b    <= w_seen_b_next;
      r_timed_out <= w_timed_out_next;
      r_timer     <= w_timer_next;
      if ((r_state == S_EMIT) && (r_count != {CNT_W{1'b1}})) begin
        r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_count <= r_count;
      end
    end
  end

  assign bus.O         = r_o;
  assign bus.state     = r_state;
  assign bus.seen_a    = r_seen_a;
  assign bus.seen_b    = r_seen_b;
  assign bus.timed_out = r_timed_out;
  assign bus.o_count   = r_count;
endmodule

// File: tb/tb_abro_sequencer.sv
// Self-checking bench: directed ABRO scenarios then random stimulus, compared against an event-level model.
// A second instance with a 2-bit counter shares the stimulus to exercise counter saturation.
module tb_abro_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       r_s = 1'b0, a_s = 1'b0, b_s = 1'b0, en_s = 1'b0;
  logic [7:0] cfg_s = 8'd0;
  int         checks = 0;
  int         failures = 0;

  // Model: what has been seen, whether a pulse is pending, whether the round ended.
  bit m_seen_a, m_seen_b, m_emit, m_done, m_to;
  int m_part, m_cnt, m_cnt2;

  abro_sequencer_if #(.TIMEOUT_W(8), .CNT_W(8)) bus8 ();
  abro_sequencer_if #(.TIMEOUT_W(8), .CNT_W(2)) bus2 ();

  assign bus8.R = r_s;  assign bus8.A = a_s;  assign bus8.B = b_s;
  assign bus8.timeout_en = en_s;  assign bus8.timeout_cfg = cfg_s;
  assign bus2.R = r_s;  assign bus2.A = a_s;  assign bus2.B = b_s;
  assign bus2.timeout_en = en_s;  assign bus2.timeout_cfg = cfg_s;

  abro_sequencer #(.TIMEOUT_W(8), .CNT_W(8)) dut (.clk(clk), .reset(rst_n), .bus(bus8));
  abro_sequencer #(.TIMEOUT_W(8), .CNT_W(2)) dut2 (.clk(clk), .reset(rst_n), .bus(bus2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_state();
    if (m_emit) return 3;
    if (m_to) return 5;
    if (m_done) return 4;
    if (m_seen_a && !m_seen_b) return 2;
    if (m_seen_b && !m_seen_a) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_seen_a = 0; m_seen_b = 0; m_emit = 0; m_done = 0; m_to = 0;
    m_part = 0; m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, {29'd0, bus8.state}, exp_state());
    chk({tag, ".O"}, {31'd0, bus8.O}, {31'd0, m_emit});
    chk({tag, ".seen_a"}, {31'd0, bus8.seen_a}, {31'd0, m_seen_a});
    chk({tag, ".seen_b"}, {31'd0, bus8.seen_b}, {31'd0, m_seen_b});
    chk({tag, ".timed_out"}, {31'd0, bus8.timed_out}, {31'd0, m_to});
    chk({tag, ".o_count"}, {24'd0, bus8.o_count}, m_cnt);
    chk({tag, ".o_count2"}, {30'd0, bus2.o_count}, m_cnt2);
  endtask

  // Drive one cycle of inputs, advance the model by one edge, check at the next falling edge.
  task automatic step(input string tag, input bit r, input bit a, input bit b);
    bit n_sa, n_sb, n_emit, n_done, n_to, inc, act;
    int n_part;
    r_s = r; a_s = a; b_s = b;
    n_sa = m_seen_a; n_sb = m_seen_b; n_emit = m_emit; n_done = m_done; n_to = m_to;
    n_part = m_part; inc = m_emit;
    act = en_s && (cfg_s != 8'd0);
    if (r) begin
      n_sa = 0; n_sb = 0; n_emit = 0; n_done = 0; n_to = 0; n_part = 0;
    end else if (m_emit) begin
      n_emit = 0; n_done = 1;
    end else if (!(m_done || m_to)) begin
      if ((m_seen_a || a) && (m_seen_b || b)) begin
        n_emit = 1; n_sa = 1; n_sb = 1; n_part = 0;
      end else if (m_seen_a || m_seen_b) begin
        if (act) begin
          if (m_part + 1 >= int'(cfg_s)) n_to = 1;
          else n_part = m_part + 1;
        end
      end else begin
        n_sa = a; n_sb = b; n_part = 0;
      end
    end
    @(posedge clk);
    m_seen_a = n_sa; m_seen_b = n_sb; m_emit = n_emit; m_done = n_done; m_to = n_to;
    m_part = n_part;
    if (inc) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // A, gap, B: 0 -> 2 -> 2 -> 3 -> 4
    step("seqA", 0, 1, 0);
    step("seqGap", 0, 0, 0);
    step("seqB", 0, 0, 1);
    step("seqEmitToHalt", 0, 0, 0);
    step("seqHalt", 0, 0, 0);

    // Simultaneous A&B, then held for 10 more cycles
    step("rearm1", 1, 0, 0);
    step("both", 0, 1, 1);
    for (int i = 0; i < 10; i++) step("bothHeld", 0, 1, 1);

    // R with A&B in HALT: R wins
    step("rWins", 1, 1, 1);
    step("second", 0, 1, 1);
    step("secondHalt", 0, 0, 0);

    // Timeout after 4 edges in WAIT_A
    en_s = 1'b1; cfg_s = 8'd4;
    step("rearmTo", 1, 0, 0);
    step("toB", 0, 0, 1);
    for (int i = 0; i < 3; i++) step("toWait", 0, 0, 0);
    step("toExpire", 0, 0, 0);
    step("toHold", 0, 1, 1);
    step("toClear", 1, 0, 0);

    // Completion on the expiry edge wins
    step("cwB", 0, 0, 1);
    for (int i = 0; i < 3; i++) step("cwWait", 0, 0, 0);
    step("cwA", 0, 1, 0);
    step("cwHalt", 0, 0, 0);

    // Freeze the timer with timeout_en low, then resume
    step("frzR", 1, 0, 0);
    step("frzA", 0, 1, 0);
    step("frz1", 0, 0, 0);
    en_s = 1'b0;
    for (int i = 0; i < 6; i++) step("frzHold", 0, 0, 0);
    en_s = 1'b1;
    step("frz2", 0, 0, 0);
    step("frz3", 0, 0, 0);
    step("frzExpire", 0, 0, 0);

    // Async reset in the middle of EMIT
    step("arR", 1, 0, 0);
    step("arAB", 0, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("asyncReset");
    @(negedge clk);
    rst_n = 1'b1;

    // Five match/R rounds saturate the 2-bit counter at 3
    en_s = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step("satAB", 0, 1, 1);
      step("satHalt", 0, 0, 0);
      step("satR", 1, 0, 0);
    end
    chk("sat.count2", {30'd0, bus2.o_count}, 32'd3);
    chk("sat.count8", {24'd0, bus8.o_count}, 32'd5);

    // Random phase
    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) begin
        en_s  = 1'($urandom_range(0, 1));
        cfg_s = 8'($urandom_range(0, 6));
      end
      step("rand", ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/abro_sequencer.md
Name: abro_sequencer

Overview:
- Full ABRO controller: waits for both A and B in any order, or together, then emits a single-cycle O pulse.
- After the pulse it stays halted until R re-arms it.
- Adds an optional partial-match timeout, an emitted-pulse counter and state visibility for the surrounding test/debug logic.
- Sits in front of the ABRO output stage and replaces its bare A&&B detection with sequenced, latched event handling.

Parameters:
- TIMEOUT_W, 8, width of timeout_cfg and of the internal partial-match timer.
- CNT_W, 8, width of the o_count saturating counter.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- R  input  1  synchronous restart/re-arm, sampled on clk.
- A  input  1  event A, level sampled on clk.
- B  input  1  event B, level sampled on clk.
- timeout_en  input  1  enables partial-match timeout.
- timeout_cfg  input  TIMEOUT_W  cycles allowed in a partial state; 0 disables the timeout.
- O  output  1  registered output pulse, high exactly one cycle per match.
- state  output  3  current FSM state encoding.
- seen_a  output  1  A has been latched since the last re-arm.
- seen_b  output  1  B has been latched since the last re-arm.
- timed_out  output  1  sticky, set on timeout, cleared by R or reset.
- o_count  output  CNT_W  number of O pulses emitted, saturating.

Behaviour:
- reset low (async): state=WAIT_AB, O=0, seen_a=0, seen_b=0, timed_out=0, o_count=0, timer=0.
- States:
  - WAIT_AB=3'd0
  - WAIT_A=3'd1 (B already seen)
  - WAIT_B=3'd2 (A already seen)
  - EMIT=3'd3
  - HALT=3'd4
  - TIMEOUT=3'd5
  - Codes 6–7 are illegal and go to WAIT_AB on the next edge.
- R priority: R=1 at an edge forces, from any state, next state WAIT_AB.
  - Clears seen_a, seen_b, timed_out and the timer.
  - Does not clear o_count.
  - Overrides any A/B activity and timeout expiry on that edge.
- WAIT_AB:
  - A&B → EMIT.
  - A only → WAIT_B, seen_a=1.
  - B only → WAIT_A, seen_b=1.
  - Neither → stay.
- WAIT_A: A → EMIT, seen_a=1. Repeated B is ignored.
- WAIT_B: B → EMIT, seen_b=1. Repeated A is ignored.
- EMIT: O=1 for this single cycle (Moore, O = state==EMIT). o_count increments at the edge leaving EMIT, saturating at 2^CNT_W-1. Next state is always HALT unless R.
- HALT: O=0. A and B are ignored and seen flags hold. Only R exits.
- Latency: a completing event sampled at edge N → O high from edge N to edge N+1 → O low after edge N+1. No combinational path from A/B to O.
- Timeout, active only when timeout_en=1 and timeout_cfg≠0:
  - The timer is cleared on entry to WAIT_A/WAIT_B.
  - It increments each edge spent in WAIT_A/WAIT_B without the completing event.
  - When the timer reaches timeout_cfg → next state TIMEOUT, timed_out=1.
  - If the completing event arrives on the same edge as expiry, completion wins: → EMIT, no timeout.
  - TIMEOUT behaves like HALT (O=0, A/B ignored) until R.
  - timeout_en deasserted mid-count freezes the timer. It resumes when re-enabled.
  - timeout_cfg changes are used from the next edge.
  - The timer never runs in WAIT_AB, EMIT, HALT or TIMEOUT.
- O never asserts twice without an intervening R.

Test Plan:
- Reset then A=1 for 1 cycle, B=1 two cycles later → state 0→2→3→4, O high exactly 1 cycle, o_count=1, seen_a=seen_b=1.
- A=B=1 on the same edge after reset → EMIT on the next cycle, O pulse 1 cycle, then HALT. Holding A=B=1 for 10 more cycles gives no further O.
- In HALT pulse R=1 together with A=B=1 → WAIT_AB, seen flags 0, no O. Next A&B → second pulse, o_count=2.
- timeout_en=1, timeout_cfg=4, B only → WAIT_A. No A for 4 edges → state=5, timed_out=1, O stays 0. R → state 0, timed_out=0.
- timeout_cfg=4, B, then A arrives exactly on the 4th edge → EMIT (completion wins), timed_out=0.
- Async reset asserted mid-EMIT (O=1) → O=0, o_count=0 and state=0 immediately, without waiting for a clk edge. CNT_W=2 with 5 match/R rounds → o_count saturates at 3.
